complex_divider_seq: RTL and testbench

//  Sequential complex divider q = a/b = a*conj(b)/|b|^2, the inverse of complex_multiplier.

---
 rtl/complex_divider_seq.sv | 154 +++++++++++++++
 tb/tb_complex_divider_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/complex_divider_seq.sv
// rtl/complex_divider_seq.sv - sequential complex divider q = a*conj(b)/|b|^2
`timescale 1ns/1ps
module complex_divider_seq #(
    parameter int W    = 16,
    parameter int FRAC = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] ar,
    input  logic [W-1:0] ai,
    input  logic [W-1:0] br,
    input  logic [W-1:0] bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] qr,
    output logic [W-1:0] qi,
    output logic         sat,
    output logic         dz
);
    localparam int AW = 2*W + 1;
    localparam int NB = AW + FRAC;
    localparam int CW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, HOLD} state_t;
    state_t state, state_nxt;

    logic [W-1:0]          ar_q, ai_q, br_q, bi_q;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  nr, ni;
    logic [AW-1:0]         den, den_fin, mag_r, mag_i;
    logic [NB-1:0]         dq_r, dq_i;
    logic [AW-1:0]         rem_r, rem_i;
    logic                  neg_r, neg_i, dz_pend;
    logic [W-1:0]          mul_x, mul_y;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  prod_x;
    logic [AW:0]           trial_r, trial_i;
    logic                  ge_r, ge_i;
    logic [W:0]            fin_r, fin_i;

    // Returns {clipped, value}: reapplies the sign and clamps to the W-bit range.
    function automatic logic [W:0] fin_half(input logic neg, input logic [NB-1:0] mag);
        logic [NB-1:0] lim;
        lim = neg ? NB'(2**(W-1)) : NB'(2**(W-1) - 1);
        if (mag > lim)
            fin_half = {1'b1, neg, {(W-1){~neg}}};
        else
            fin_half = {1'b0, (neg ? W'(-mag[W-1:0]) : mag[W-1:0])};
    endfunction

    always_comb begin
        mul_x = ar_q;
        mul_y = br_q;
        case (cnt[2:0])
            3'd1:    begin mul_x = ai_q; mul_y = bi_q; end
            3'd2:    begin mul_x = ai_q; mul_y = br_q; end
            3'd3:    begin mul_x = ar_q; mul_y = bi_q; end
            3'd4:    begin mul_x = br_q; mul_y = br_q; end
            3'd5:    begin mul_x = bi_q; mul_y = bi_q; end
            default: begin mul_x = ar_q; mul_y = br_q; end
        endcase
        prod    = $signed({{W{mul_x[W-1]}}, mul_x}) * $signed({{W{mul_y[W-1]}}, mul_y});
        prod_x  = {prod[2*W-1], prod};
        den_fin = den + prod_x;
        mag_r   = nr[AW-1] ? -nr : nr;
        mag_i   = ni[AW-1] ? -ni : ni;
        trial_r = {rem_r, dq_r[NB-1]};
        trial_i = {rem_i, dq_i[NB-1]};
        ge_r    = trial_r >= {1'b0, den};
        ge_i    = trial_i >= {1'b0, den};
        fin_r   = fin_half(neg_r, dq_r);
        fin_i   = fin_half(neg_i, dq_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = MUL;
            MUL:  if (cnt == CW'(5)) state_nxt = (den_fin == '0) ? FIN : DIV;
            DIV:  if (cnt == CW'(NB-1)) state_nxt = FIN;
            FIN:  state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
            cnt <= '0; nr <= '0; ni <= '0; den <= '0;
            dq_r <= '0; dq_i <= '0; rem_r <= '0; rem_i <= '0;
            neg_r <= 1'b0; neg_i <= 1'b0; dz_pend <= 1'b0;
            qr <= '0; qi <= '0; sat <= 1'b0; dz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ar_q <= ar; ai_q <= ai; br_q <= br; bi_q <= bi;
                    cnt  <= '0;
                end
                MUL: begin
                    cnt <= cnt + CW'(1);
                    case (cnt[2:0])
                        3'd0: nr  <= prod_x;
                        3'd1: nr  <= nr + prod_x;
                        3'd2: ni  <= prod_x;
                        3'd3: ni  <= ni - prod_x;
                        3'd4: den <= prod_x;
                        3'd5: begin
                            // Last product lands here; the dividers are seeded in the same edge.
                            den     <= den_fin;
                            dz_pend <= (den_fin == '0);
                            neg_r   <= nr[AW-1];
                            neg_i   <= ni[AW-1];
                            dq_r    <= {mag_r, {FRAC{1'b0}}};
                            dq_i    <= {mag_i, {FRAC{1'b0}}};
                            rem_r   <= '0;
                            rem_i   <= '0;
                            cnt     <= '0;
                        end
                        default: ;
                    endcase
                end
                DIV: begin
                    cnt   <= cnt + CW'(1);
                    dq_r  <= {dq_r[NB-2:0], ge_r};
                    dq_i  <= {dq_i[NB-2:0], ge_i};
                    rem_r <= ge_r ? AW'(trial_r - {1'b0, den}) : trial_r[AW-1:0];
                    rem_i <= ge_i ? AW'(trial_i - {1'b0, den}) : trial_i[AW-1:0];
                end
                FIN: begin
                    if (dz_pend) begin
                        qr <= '0; qi <= '0; sat <= 1'b0; dz <= 1'b1;
                    end else begin
                        qr  <= fin_r[W-1:0];
                        qi  <= fin_i[W-1:0];
                        sat <= fin_r[W] | fin_i[W];
                        dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_divider_seq.sv
// tb/tb_complex_divider_seq.sv - self-checking bench for complex_divider_seq
`timescale 1ns/1ps
module tb_complex_divider_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, sat, dz;
    logic [15:0] ar, ai, br, bi, qr, qi;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    complex_divider_seq #(.W(16), .FRAC(14)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .qr(qr), .qi(qi), .sat(sat), .dz(dz)
    );

    typedef struct {
        int     a_r, a_i, b_r, b_i;
        longint e_qr, e_qi, e_sat, e_dz;
        int     e_lat;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint clip16(input longint v, inout longint c);
        if (v > 32767)  begin c = 1; return 32767;  end
        if (v < -32768) begin c = 1; return -32768; end
        return v;
    endfunction

    function automatic void model(input longint a_r, a_i, b_r, b_i,
                                  output longint e_qr, e_qi, e_sat, e_dz);
        longint n_r, n_i, d, c;
        n_r = a_r * b_r + a_i * b_i;
        n_i = a_i * b_r - a_r * b_i;
        d   = b_r * b_r + b_i * b_i;
        c   = 0;
        if (d == 0) begin
            e_qr = 0; e_qi = 0; e_sat = 0; e_dz = 1;
        end else begin
            e_qr  = clip16((n_r * 16384) / d, c);
            e_qi  = clip16((n_i * 16384) / d, c);
            e_sat = c;
            e_dz  = 0;
        end
    endfunction

    task automatic send(input int a_r, a_i, b_r, b_i);
        int n;
        n = 0;
        ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) break;
        end
        chk("send.ready", longint'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 300);
        chk("wait.valid", longint'(out_valid), 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input int a_r, a_i, b_r, b_i,
                          input longint e_qr, e_qi, e_sat, e_dz, input int e_lat);
        int lat;
        send(a_r, a_i, b_r, b_i);
        wait_out(lat);
        chk({tag, ".qr"},  longint'($signed(qr)), e_qr);
        chk({tag, ".qi"},  longint'($signed(qi)), e_qi);
        chk({tag, ".sat"}, longint'(sat), e_sat);
        chk({tag, ".dz"},  longint'(dz), e_dz);
        chk({tag, ".lat"}, longint'(lat), longint'(e_lat));
        take();
        chk({tag, ".drop"}, longint'(out_valid), 0);
        chk({tag, ".idle"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint m_qr, m_qi, m_sat, m_dz;
        int     x_r, x_i, y_r, y_i, mode, lat;

        tbl[0] = '{16384, 0, 16384, 0, 16384, 0, 0, 0, 54};
        tbl[1] = '{1, 2, 3, 4, 7208, 1310, 0, 0, 54};
        tbl[2] = '{-1, -2, 3, 4, -7208, -1310, 0, 0, 54};
        tbl[3] = '{32767, -32768, 1, 0, 32767, -32768, 1, 0, 54};
        tbl[4] = '{123, -456, 0, 0, 0, 0, 0, 1, 7};
        tbl[5] = '{-32768, -32768, -32768, -32768, 16384, 0, 0, 0, 54};
        tbl[6] = '{0, 0, 5, 7, 0, 0, 0, 0, 54};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.in_ready",  longint'(in_ready), 1);
        chk("rst.out_valid", longint'(out_valid), 0);
        chk("rst.qr",  longint'($signed(qr)), 0);
        chk("rst.qi",  longint'($signed(qi)), 0);
        chk("rst.sat", longint'(sat), 0);
        chk("rst.dz",  longint'(dz), 0);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a_r, tbl[i].a_i, tbl[i].b_r, tbl[i].b_i,
                   tbl[i].e_qr, tbl[i].e_qi, tbl[i].e_sat, tbl[i].e_dz, tbl[i].e_lat);

        // Result held under backpressure; input ignored until the result is taken.
        send(1, 2, 3, 4);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            ar = 16'(i * 7); br = 16'(i + 1);
            @(posedge clk);
            #1;
            chk("hold.qr", longint'($signed(qr)), 7208);
            chk("hold.qi", longint'($signed(qi)), 1310);
            chk("hold.valid", longint'(out_valid), 1);
            chk("hold.ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        take();
        chk("hold.drop", longint'(out_valid), 0);
        chk("hold.idle", longint'(in_ready), 1);
        send(16384, 0, 16384, 0);
        chk("hold.accept", longint'(in_ready), 0);
        wait_out(lat);
        chk("hold.next.qr",  longint'($signed(qr)), 16384);
        chk("hold.next.lat", longint'(lat), 54);
        take();

        // Reset in the middle of the division phase.
        send(1, 2, 3, 4);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid.in_ready",  longint'(in_ready), 1);
        chk("mid.out_valid", longint'(out_valid), 0);
        chk("mid.qr", longint'($signed(qr)), 0);
        run_op("mid.fresh", -1, -2, 3, 4, -7208, -1310, 0, 0, 54);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            x_r = int'($signed(16'($urandom)));
            x_i = int'($signed(16'($urandom)));
            y_r = int'($signed(16'($urandom)));
            y_i = int'($signed(16'($urandom)));
            if (mode >= 1) begin
                x_r = int'($urandom_range(0, 600)) - 300;
                x_i = int'($urandom_range(0, 600)) - 300;
            end
            if (mode == 2) begin
                y_r = int'($urandom_range(0, 60)) - 30;
                y_i = int'($urandom_range(0, 60)) - 30;
            end
            if (mode == 3 && i % 4 == 0) begin
                y_r = 0; y_i = 0;
            end
            model(longint'(x_r), longint'(x_i), longint'(y_r), longint'(y_i),
                  m_qr, m_qi, m_sat, m_dz);
            run_op($sformatf("rnd%0d", i), x_r, x_i, y_r, y_i,
                   m_qr, m_qi, m_sat, m_dz, (m_dz != 0) ? 7 : 54);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
